frame_writer: RTL and testbench

- Sits directly downstream of the pixel-scan/draw stage.
- Consumes its raster stream of (x, y, colour) and writes each pixel into the video frame memory through a ready/write handshake.
- Decouples the one-pixel-per-clock producer from a memory port that may stall, using a small FIFO and a two-state write FSM.
- Flags frame completion and counts pixels lost to overflow.

---
 rtl/frame_writer_if.sv | 34 +++
 rtl/frame_writer.sv | 124 ++++++++++++
 tb/tb_frame_writer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_writer_if.sv
// frame_writer_if: groups the pixel stream and frame-memory write bus of
// frame_writer.
//   x_in/y_in/colour_in/pixel_valid : pixel stream from the draw stage
//   mem_ready                       : memory accepts the presented write
//   mem_write/mem_addr/mem_data     : write request to frame memory
// Modport slave is the frame_writer view (consumes pixels, drives memory);
// modport master is the environment view (draw stage + memory).
//
// Handshake: a write transfers on every rising edge where mem_write=1 and
// mem_ready=1. While mem_write=1 and mem_ready=0, mem_addr/mem_data hold
// stable. pixel_valid is a one-cycle qualifier with no back-pressure; the
// producer learns of a full FIFO only through fifo_full.
interface frame_writer_if #(
  parameter int ADDR_W = 17
);
  logic [8:0]        x_in;
  logic [8:0]        y_in;
  logic [2:0]        colour_in;
  logic              pixel_valid;
  logic              mem_ready;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_data;

  modport slave (
    input  x_in, y_in, colour_in, pixel_valid, mem_ready,
    output mem_write, mem_addr, mem_data
  );

  modport master (
    output x_in, y_in, colour_in, pixel_valid, mem_ready,
    input  mem_write, mem_addr, mem_data
  );
endinterface

// File: rtl/frame_writer.sv
// frame_writer: buffers the raster pixel stream in a small FIFO and writes
// each pixel into frame memory at y*SCREEN_W + x.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : pixel stream in / memory write out (frame_writer_if.slave)
//   max_x, max_y : last valid column / row index; also define the frame's
//                  final pixel for frame_done
//   fifo_full    : FIFO holds FIFO_DEPTH entries
//   drop_count   : in-range pixels lost to overflow, saturating
//   frame_done   : one-cycle pulse after pixel (max_x, max_y) is written
//   state_dbg    : 1 while the write FSM is in WRITE
module frame_writer #(
  parameter int SCREEN_W   = 320,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 17
) (
  input  logic                clock,
  input  logic                reset,
  frame_writer_if.slave       bus,
  input  logic [8:0]          max_x,
  input  logic [8:0]          max_y,
  output logic                fifo_full,
  output logic [15:0]         drop_count,
  output logic                frame_done,
  output logic                state_dbg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;

  logic [8:0] fx [FIFO_DEPTH];
  logic [8:0] fy [FIFO_DEPTH];
  logic [2:0] fc [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [2:0]        mem_data_q;
  logic [8:0]        out_x, out_y;

  logic in_range, push, drop, pop, accept;
  logic [ADDR_W-1:0] head_addr;

  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign state_dbg     = (state == WRITE);

  // Fullness comes from registered occupancy only: a pop this cycle does
  // not open a slot for a push this cycle.
  assign fifo_full = (count == FULL_CNT);
  assign in_range  = (bus.x_in <= max_x) && (bus.y_in <= max_y);
  assign push      = bus.pixel_valid && in_range && !fifo_full;
  assign drop      = bus.pixel_valid && in_range && fifo_full;
  assign accept    = (state == WRITE) && bus.mem_ready;
  // IDLE loads unconditionally; WRITE only refills when the current write
  // is being accepted.
  assign pop       = (count != '0) && ((state == IDLE) || accept);

  // Full-width product so no intermediate term is truncated.
  assign head_addr = ADDR_W'(fy[rd_ptr]) * ADDR_W'(SCREEN_W) + ADDR_W'(fx[rd_ptr]);

  // FIFO storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      fx[wr_ptr] <= bus.x_in;
      fy[wr_ptr] <= bus.y_in;
      fc[wr_ptr] <= bus.colour_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      out_x       <= '0;
      out_y       <= '0;
      frame_done  <= 1'b0;
      drop_count  <= '0;
    end else begin
      frame_done <= accept && (out_x == max_x) && (out_y == max_y);

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;

      if (pop) begin
        mem_addr_q <= head_addr;
        mem_data_q <= fc[rd_ptr];
        out_x      <= fx[rd_ptr];
        out_y      <= fy[rd_ptr];
      end

      case (state)
        IDLE: begin
          if (pop) begin
            mem_write_q <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_ready && !pop) begin
            mem_write_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_writer.sv
module tb_frame_writer;
  localparam int ADDR_W = 17;
  localparam int W      = ADDR_W + 3;

  logic        clock;
  logic        reset;
  logic [8:0]  max_x, max_y;
  logic        fifo_full;
  logic [15:0] drop_count;
  logic        frame_done;
  logic        state_dbg;

  frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

  frame_writer #(.SCREEN_W(320), .FIFO_DEPTH(8), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .max_x      (max_x),
    .max_y      (max_y),
    .fifo_full  (fifo_full),
    .drop_count (drop_count),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int fd_cnt   = 0;
  logic [ADDR_W-1:0] last_acc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Monitor: sample mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_done) begin
        fd_cnt++;
        chk("frame_done_after_addr", 32'(last_acc), 32'd76799);
      end
      if (bus.mem_write && bus.mem_ready) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
        else chk("write_order", 32'({bus.mem_addr, bus.mem_data}), 32'(exp_q.pop_front()));
        wr_cnt++;
        last_acc = bus.mem_addr;
      end
    end
  end

  // ---------------- driver tasks (called at posedge+#1) ----------------
  function automatic logic [W-1:0] exp_word(input int x, input int y, input int c);
    logic [ADDR_W-1:0] a;
    logic [2:0] col;
    a   = ADDR_W'(y * 320 + x);
    col = 3'(c);
    return {a, col};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_px(input int x, input int y, input int c, input bit expect_write);
    bus.x_in        = 9'(x);
    bus.y_in        = 9'(y);
    bus.colour_in   = 3'(c);
    bus.pixel_valid = 1'b1;
    if (expect_write) exp_q.push_back(exp_word(x, y, c));
    step(1);
  endtask

  task automatic idle_in();
    bus.pixel_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !bus.mem_write) break;
      step(1);
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_mem_write_low", 32'(bus.mem_write), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int a0;
    reset = 1'b1;
    max_x = 9'd319;
    max_y = 9'd239;
    bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0;
    bus.pixel_valid = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    step(1);

    // Single pixel: write appears after the edge following the push.
    push_px(5, 2, 5, 1'b1);
    idle_in();
    chk("single_not_yet", 32'(bus.mem_write), 32'd0);
    step(1);
    chk("single_write", 32'(bus.mem_write), 32'd1);
    chk("single_addr", 32'(bus.mem_addr), 32'd645);
    chk("single_data", 32'(bus.mem_data), 32'd5);
    step(1);
    chk("single_drop_write", 32'(bus.mem_write), 32'd0);
    chk("single_queue", 32'(exp_q.size()), 32'd0);

    // Stall and hold: first pixel held, then three back-to-back writes.
    bus.mem_ready = 1'b0;
    push_px(10, 1, 1, 1'b1);
    push_px(11, 1, 2, 1'b1);
    push_px(0, 239, 7, 1'b1);
    idle_in();
    step(3);
    chk("stall_write_held", 32'(bus.mem_write), 32'd1);
    chk("stall_addr_held", 32'(bus.mem_addr), 32'd330);
    chk("stall_data_held", 32'(bus.mem_data), 32'd1);
    w0 = wr_cnt;
    bus.mem_ready = 1'b1;
    step(3);
    chk("stall_b2b_writes", 32'(wr_cnt - w0), 32'd3);
    chk("stall_idle_after", 32'(bus.mem_write), 32'd0);

    // Overflow: 1 in output regs + 8 in FIFO, last 2 dropped.
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 11; i++) push_px(20 + i, 3, i % 8, i < 9);
    idle_in();
    chk("ovf_fifo_full", 32'(fifo_full), 32'd1);
    chk("ovf_drop_count", 32'(drop_count), 32'd2);
    chk("ovf_head_addr", 32'(bus.mem_addr), 32'd980);
    w0 = wr_cnt;
    bus.mem_ready = 1'b1;
    wait_drain(30);
    chk("ovf_write_count", 32'(wr_cnt - w0), 32'd9);
    chk("ovf_fifo_not_full", 32'(fifo_full), 32'd0);

    // Range filter: out-of-range x is neither written nor counted.
    w0 = wr_cnt;
    push_px(320, 0, 3, 1'b0);
    push_px(4, 240, 3, 1'b0);
    idle_in();
    step(4);
    chk("range_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("range_drop_same", 32'(drop_count), 32'd2);

    // Mid-write reset: outputs clear without a clock edge.
    bus.mem_ready = 1'b0;
    push_px(7, 7, 6, 1'b0);
    push_px(8, 7, 6, 1'b0);
    idle_in();
    step(1);
    chk("mid_pre_write", 32'(bus.mem_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_write", 32'(bus.mem_write), 32'd0);
    chk("mid_rst_full", 32'(fifo_full), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    step(1);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("post_rst_quiet", 32'(bus.mem_write), 32'd0);
    end
    chk("post_rst_no_writes", 32'(wr_cnt - w0), 32'd0);

    // Full frame streamed at one pixel per clock.
    w0 = wr_cnt;
    fd_cnt = 0;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 320; x++)
        push_px(x, y, $urandom_range(0, 7), 1'b1);
    idle_in();
    wait_drain(50);
    step(2);
    chk("frame_writes", 32'(wr_cnt - w0), 32'd76800);
    chk("frame_drop_zero", 32'(drop_count), 32'd0);
    chk("frame_done_pulses", 32'(fd_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
